// File: rtl/mc_datapath_if.sv
// Control bundle and unified memory port between the multicycle controller/memory and the datapath.
interface mc_datapath_if;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [1:0]  ImmSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [2:0]  ALUControl;
  logic        IRWrite;
  logic        AdrSrc;
  logic        PCWrite;
  logic        B;
  logic [31:0] ReadData;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;

  modport master (
    output RegSrc, RegWrite, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
           IRWrite, AdrSrc, PCWrite, B, ReadData,
    input  Adr, WriteData, Instr, ALUFlags
  );

  modport slave (
    input  RegSrc, RegWrite, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
           IRWrite, AdrSrc, PCWrite, B, ReadData,
    output Adr, WriteData, Instr, ALUFlags
  );
endinterface

// File: rtl/mc_datapath.sv
// Multicycle ARM-subset datapath: PC/IR/Data/A/WriteData/ALUOut registers, 15-entry
// register file, immediate extender and flag-producing ALU.
module mc_datapath #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  mc_datapath_if.slave bus_io
);

  logic [31:0] pc_q, ir_q, data_q, a_q, wd_q, aluout_q;
  logic [31:0] rf_q [15];

  logic [3:0]  ra1, ra2, wa;
  logic [31:0] rd1, rd2;
  logic [31:0] ext_imm, src_a, src_b;
  logic [32:0] add_sum, sub_sum;
  logic [31:0] alu_result, result;
  logic        alu_c, alu_v;

  assign ra1 = bus_io.RegSrc[0] ? 4'd15 : ir_q[19:16];
  assign ra2 = bus_io.RegSrc[1] ? ir_q[15:12] : ir_q[3:0];
  assign wa  = bus_io.B ? 4'd14 : ir_q[15:12];

  always_comb begin
    ext_imm = 32'h0;
    unique case (bus_io.ImmSrc)
      2'b00: ext_imm = {24'h0, ir_q[7:0]};
      2'b01: ext_imm = {20'h0, ir_q[11:0]};
      2'b10: ext_imm = {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
      2'b11: ext_imm = 32'h0;
    endcase
  end

  assign src_a = bus_io.ALUSrcA ? pc_q : a_q;

  always_comb begin
    src_b = 32'h0;
    unique case (bus_io.ALUSrcB)
      2'b00: src_b = wd_q;
      2'b01: src_b = ext_imm;
      2'b10: src_b = 32'd4;
      2'b11: src_b = 32'h0;
    endcase
  end

  assign add_sum = {1'b0, src_a} + {1'b0, src_b};
  assign sub_sum = {1'b0, src_a} + {1'b0, ~src_b} + 33'd1;

  always_comb begin
    alu_result = 32'h0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    case (bus_io.ALUControl)
      3'b000: begin
        alu_result = add_sum[31:0];
        alu_c      = add_sum[32];
        alu_v      = (src_a[31] == src_b[31]) && (add_sum[31] != src_a[31]);
      end
      3'b001: begin
        alu_result = sub_sum[31:0];
        alu_c      = sub_sum[32];
        alu_v      = (src_a[31] != src_b[31]) && (sub_sum[31] != src_a[31]);
      end
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b100:  alu_result = src_a ^ src_b;
      3'b101:  alu_result = src_b;
      default: alu_result = 32'h0;
    endcase
  end

  always_comb begin
    result = aluout_q;
    unique case (bus_io.ResultSrc)
      2'b00: result = aluout_q;
      2'b01: result = data_q;
      2'b10: result = alu_result;
      2'b11: result = aluout_q;
    endcase
  end

  // Address 15 is the PC view: it reads the live Result bus instead of storage.
  always_comb begin
    rd1 = result;
    rd2 = result;
    for (int i = 0; i < 15; i++) begin
      if (ra1 == 4'(i)) rd1 = rf_q[i];
      if (ra2 == 4'(i)) rd2 = rf_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= PC_RESET;
      ir_q     <= 32'h0;
      data_q   <= 32'h0;
      a_q      <= 32'h0;
      wd_q     <= 32'h0;
      aluout_q <= 32'h0;
    end else begin
      data_q   <= bus_io.ReadData;
      a_q      <= rd1;
      wd_q     <= rd2;
      aluout_q <= alu_result;
      if (bus_io.IRWrite) ir_q <= bus_io.ReadData;
      if (bus_io.PCWrite) pc_q <= result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 15; i++) rf_q[i] <= 32'h0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (bus_io.RegWrite && (wa == 4'(i))) rf_q[i] <= result;
      end
    end
  end

  assign bus_io.Adr       = bus_io.AdrSrc ? result : pc_q;
  assign bus_io.WriteData = wd_q;
  assign bus_io.Instr     = ir_q;
  assign bus_io.ALUFlags  = {alu_result[31], (alu_result == 32'h0), alu_c, alu_v};

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: arithmetic reference model checked every cycle, plus directed
// instruction-like sequences with hand-computed literal expectations.
module tb_mc_datapath;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  mc_datapath_if dp ();

  mc_datapath #(.PC_RESET(32'h0000_0000)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (dp)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_ir, m_data, m_a, m_wd, m_aluout;
  logic [31:0] m_rf [16];
  logic [31:0] e_ext, e_srca, e_srcb, e_res, e_adr, e_rd1, e_rd2;
  logic [35:0] e_alu;
  logic [3:0]  e_ra1, e_ra2, e_wa;

  function automatic logic [35:0] m_alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s  = 0;
    logic [31:0] r = 32'h0;
    logic c = 1'b0;
    logic v = 1'b0;
    case (op)
      3'd0: begin
        r = 32'(ua + ub);
        c = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
        s = sa + sb;
        v = (s != longint'($signed(r)));
      end
      3'd1: begin
        r = 32'(ua - ub);
        c = (ua >= ub);
        s = sa - sb;
        v = (s != longint'($signed(r)));
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = b;
      default: r = 32'h0;
    endcase
    return {r[31], (r == 32'h0), c, v, r};
  endfunction

  function automatic logic [31:0] m_ext_imm(input logic [31:0] ir, input logic [1:0] sel);
    logic [23:0] off = ir[23:0];
    case (sel)
      2'd0: return 32'(ir[7:0]);
      2'd1: return 32'(ir[11:0]);
      2'd2: return 32'(longint'($signed(off)) * 4);
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    e_ext  = m_ext_imm(m_ir, dp.ImmSrc);
    e_srca = dp.ALUSrcA ? m_pc : m_a;
    case (dp.ALUSrcB)
      2'd0: e_srcb = m_wd;
      2'd1: e_srcb = e_ext;
      2'd2: e_srcb = 32'd4;
      default: e_srcb = 32'd0;
    endcase
    e_alu = m_alu(e_srca, e_srcb, dp.ALUControl);
    case (dp.ResultSrc)
      2'd1: e_res = m_data;
      2'd2: e_res = e_alu[31:0];
      default: e_res = m_aluout;
    endcase
    e_adr = dp.AdrSrc ? e_res : m_pc;
    e_ra1 = dp.RegSrc[0] ? 4'd15 : m_ir[19:16];
    e_ra2 = dp.RegSrc[1] ? m_ir[15:12] : m_ir[3:0];
    e_rd1 = (e_ra1 == 4'd15) ? e_res : m_rf[e_ra1];
    e_rd2 = (e_ra2 == 4'd15) ? e_res : m_rf[e_ra2];
    e_wa  = dp.B ? 4'd14 : m_ir[15:12];
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc <= 32'h0; m_ir <= 32'h0; m_data <= 32'h0;
      m_a <= 32'h0; m_wd <= 32'h0; m_aluout <= 32'h0;
      for (int i = 0; i < 16; i++) m_rf[i] <= 32'h0;
    end else begin
      m_data   <= dp.ReadData;
      m_a      <= e_rd1;
      m_wd     <= e_rd2;
      m_aluout <= e_alu[31:0];
      if (dp.IRWrite) m_ir <= dp.ReadData;
      if (dp.PCWrite) m_pc <= e_res;
      if (dp.RegWrite && e_wa != 4'd15) m_rf[e_wa] <= e_res;
    end
  end

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_adr", dp.Adr, e_adr);
      cmp("model_wdata", dp.WriteData, m_wd);
      cmp("model_instr", dp.Instr, m_ir);
      cmp("model_flags", 32'(dp.ALUFlags), 32'(e_alu[35:32]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    dp.RegSrc = 2'b00; dp.RegWrite = 1'b0; dp.ImmSrc = 2'b00; dp.ALUSrcA = 1'b0;
    dp.ALUSrcB = 2'b00; dp.ResultSrc = 2'b00; dp.ALUControl = 3'b000;
    dp.IRWrite = 1'b0; dp.AdrSrc = 1'b0; dp.PCWrite = 1'b0; dp.B = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [31:0] w);
    idle();
    dp.IRWrite  = 1'b1;
    dp.ReadData = w;
    step();
    dp.IRWrite = 1'b0;
  endtask

  task automatic write_reg(input logic [3:0] rd, input logic [31:0] v);
    load_ir({16'h0, rd, 12'h0});
    dp.ReadData = v;
    step();
    dp.ResultSrc = 2'b01;
    dp.RegWrite  = 1'b1;
    step();
    idle();
  endtask

  // Route R[rn] through A and out on Adr as Result = A + 0.
  task automatic read_reg(input logic [3:0] rn, input logic [31:0] exp, input string nm);
    load_ir({12'h0, rn, 16'h0});
    step();
    dp.ALUSrcA = 1'b0; dp.ALUSrcB = 2'b11; dp.ALUControl = 3'b000;
    dp.ResultSrc = 2'b10; dp.AdrSrc = 1'b1;
    #1;
    cmp(nm, dp.Adr, exp);
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    dp.ReadData = 32'h0;
    #3 reset = 1'b0;
    #1 chk_en = 1'b1;
    #8;
    cmp("rst_adr", dp.Adr, 32'h0);
    cmp("rst_instr", dp.Instr, 32'h0);
    cmp("rst_wdata", dp.WriteData, 32'h0);
    #10 reset = 1'b1;
    step();

    // Fetch
    dp.IRWrite = 1'b1; dp.ALUSrcA = 1'b1; dp.ALUSrcB = 2'b10; dp.ResultSrc = 2'b10;
    dp.PCWrite = 1'b1; dp.ReadData = 32'hE281_0005;
    #1 cmp("fetch_adr_pre", dp.Adr, 32'h0);
    step();
    idle();
    #1;
    cmp("fetch_instr", dp.Instr, 32'hE281_0005);
    cmp("fetch_pc", dp.Adr, 32'h4);

    // ADD overflow: 7FFFFFFF + 1
    write_reg(4'd1, 32'h7FFF_FFFF);
    load_ir(32'hE281_0001);
    step();
    dp.ALUSrcA = 1'b0; dp.ALUSrcB = 2'b01; dp.ImmSrc = 2'b00; dp.ALUControl = 3'b000;
    dp.ResultSrc = 2'b10; dp.AdrSrc = 1'b1;
    #1;
    cmp("add_flags", 32'(dp.ALUFlags), 32'(4'b1001));
    cmp("add_result", dp.Adr, 32'h8000_0000);
    step();
    dp.ResultSrc = 2'b00; dp.RegWrite = 1'b1;
    #1 cmp("add_aluout", dp.Adr, 32'h8000_0000);
    step();
    idle();
    read_reg(4'd0, 32'h8000_0000, "add_r0");

    // SUB equal and SUB negative
    write_reg(4'd2, 32'd5);
    write_reg(4'd3, 32'd5);
    load_ir(32'hE052_0003);
    step();
    dp.ALUSrcA = 1'b0; dp.ALUSrcB = 2'b00; dp.ALUControl = 3'b001;
    dp.ResultSrc = 2'b10; dp.AdrSrc = 1'b1;
    #1;
    cmp("sub_eq_flags", 32'(dp.ALUFlags), 32'(4'b0110));
    cmp("sub_eq_result", dp.Adr, 32'h0);
    idle();
    write_reg(4'd2, 32'd3);
    load_ir(32'hE052_0003);
    step();
    dp.ALUSrcA = 1'b0; dp.ALUSrcB = 2'b00; dp.ALUControl = 3'b001;
    dp.ResultSrc = 2'b10; dp.AdrSrc = 1'b1;
    #1;
    cmp("sub_neg_flags", 32'(dp.ALUFlags), 32'(4'b1000));
    cmp("sub_neg_result", dp.Adr, 32'hFFFF_FFFE);
    idle();

    // Branch with link from PC=0x100
    dp.ReadData = 32'h100;
    step();
    dp.ResultSrc = 2'b01; dp.PCWrite = 1'b1;
    step();
    idle();
    #1 cmp("pc_set", dp.Adr, 32'h100);
    load_ir(32'hEAFF_FFFE);
    dp.ALUSrcA = 1'b1; dp.ALUSrcB = 2'b01; dp.ImmSrc = 2'b10; dp.ALUControl = 3'b000;
    dp.ResultSrc = 2'b10; dp.AdrSrc = 1'b1; dp.B = 1'b1; dp.RegWrite = 1'b1;
    #1 cmp("br_target", dp.Adr, 32'h0000_00F8);
    step();
    idle();
    read_reg(4'd14, 32'h0000_00F8, "br_link_r14");
    read_reg(4'd0, 32'h8000_0000, "br_r0_kept");

    // STR data path, LDR writeback
    write_reg(4'd5, 32'hDEAD_BEEF);
    load_ir(32'hE581_5000);
    dp.RegSrc = 2'b10;
    step();
    cmp("str_wdata", dp.WriteData, 32'hDEAD_BEEF);
    dp.RegSrc = 2'b00; dp.ALUSrcA = 1'b0; dp.ALUSrcB = 2'b01; dp.ImmSrc = 2'b01;
    dp.ALUControl = 3'b000; dp.ResultSrc = 2'b10; dp.AdrSrc = 1'b1;
    #1 cmp("str_adr", dp.Adr, 32'h7FFF_FFFF);
    idle();
    dp.ReadData = 32'h1234_5678;
    step();
    dp.ResultSrc = 2'b01; dp.RegWrite = 1'b1;
    step();
    idle();
    read_reg(4'd5, 32'h1234_5678, "ldr_r5");

    // R15 read returns the live Result (PC + 4)
    dp.RegSrc = 2'b01; dp.ALUSrcA = 1'b1; dp.ALUSrcB = 2'b10; dp.ResultSrc = 2'b10;
    step();
    idle();
    dp.ALUSrcB = 2'b11; dp.ResultSrc = 2'b10; dp.AdrSrc = 1'b1;
    #1 cmp("r15_read", dp.Adr, 32'h104);
    idle();

    // Mid-cycle reset with writes pending
    dp.ALUSrcA = 1'b1; dp.ALUSrcB = 2'b10; dp.ResultSrc = 2'b10;
    dp.PCWrite = 1'b1; dp.RegWrite = 1'b1;
    #1 reset = 1'b0;
    #1;
    cmp("mrst_adr", dp.Adr, 32'h0);
    cmp("mrst_instr", dp.Instr, 32'h0);
    #1 reset = 1'b1;
    idle();
    step();
    cmp("mrst_pc_hold", dp.Adr, 32'h0);
    read_reg(4'd0, 32'h0, "mrst_r0");
    read_reg(4'd5, 32'h0, "mrst_r5");
    read_reg(4'd14, 32'h0, "mrst_r14");

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
